// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: bus widths, exception codes
// and the sequencer state encoding.
package pipe_stall_ctrl_pkg;

    localparam int PSC_ADDR_W = 30;
    localparam int PSC_EXP_W  = 3;

    localparam logic [PSC_ADDR_W-1:0] PSC_EXC_VECTOR = 30'h0000_0010;
    localparam int                    PSC_CP2_TIMEOUT = 16;

    localparam logic [PSC_EXP_W-1:0] ISAEXP_NOEXP    = 3'd0;
    localparam logic [PSC_EXP_W-1:0] ISAEXP_INT      = 3'd1;
    localparam logic [PSC_EXP_W-1:0] ISAEXP_CP2_TO   = 3'd6;

    typedef enum logic [1:0] {
        PSC_RUN      = 2'd0,
        PSC_CP2_WAIT = 2'd1,
        PSC_EXC      = 2'd2
    } psc_state_e;

endpackage

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline sequencer: stall/flush per stage, interrupt detect,
// exception/ERET redirect and EPC ownership for the 4-register pipeline.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int                  ADDR_W      = PSC_ADDR_W,
    parameter int                  EXP_W       = PSC_EXP_W,
    parameter logic [ADDR_W-1:0]   EXC_VECTOR  = PSC_EXC_VECTOR,
    parameter logic [EXP_W-1:0]    INT_CODE    = ISAEXP_INT,
    parameter int                  CP2_TIMEOUT = PSC_CP2_TIMEOUT,
    parameter logic [EXP_W-1:0]    CP2_TO_CODE = ISAEXP_CP2_TO
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_busy,
    input  logic              mem_busy,
    input  logic              ld_hazard,
    input  logic              mem_en,
    input  logic [ADDR_W-1:0] mem_pc,
    input  logic [EXP_W-1:0]  mem_exp_code,
    input  logic              mem_eret,
    input  logic              cp2_req,
    input  logic              cp2_ack,
    input  logic              int_req,
    input  logic              int_en,
    output logic              if_stall,
    output logic              id_stall,
    output logic              ex_stall,
    output logic              mem_stall,
    output logic              if_flush,
    output logic              id_flush,
    output logic              ex_flush,
    output logic              mem_flush,
    output logic              int_detect,
    output logic [EXP_W-1:0]  int_type,
    output logic [ADDR_W-1:0] new_pc,
    output logic [ADDR_W-1:0] epc,
    output logic [EXP_W-1:0]  exp_code,
    output logic              cp2_busy
);

    localparam int              CNT_W    = $clog2(CP2_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CP2_TIMEOUT - 1);

    psc_state_e        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              stall_all, flush_all, ld_bubble, int_hit, exc_take;
    logic [ADDR_W-1:0] redirect;
    logic [EXP_W-1:0]  exc_cause;

    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        stall_all = 1'b0;
        flush_all = 1'b0;
        ld_bubble = 1'b0;
        int_hit   = 1'b0;
        exc_take  = 1'b0;
        exc_cause = ISAEXP_NOEXP;
        redirect  = '0;
        state_nxt = state;
        cnt_nxt   = cnt;

        // While reset is held, all control outputs sit at their idle values.
        if (reset) begin
            case (state)
                PSC_RUN: begin
                    if (if_busy || mem_busy) begin
                        stall_all = 1'b1;
                    end else if (mem_en && mem_exp_code != ISAEXP_NOEXP) begin
                        flush_all = 1'b1;
                        redirect  = EXC_VECTOR;
                        exc_take  = 1'b1;
                        exc_cause = mem_exp_code;
                    end else if (mem_en && mem_eret) begin
                        flush_all = 1'b1;
                        redirect  = epc;
                    end else if (cp2_req && !cp2_ack) begin
                        stall_all = 1'b1;
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = PSC_CP2_WAIT;
                    end else if (ld_hazard) begin
                        ld_bubble = 1'b1;
                    end else begin
                        int_hit = int_req & int_en;
                    end
                end
                PSC_CP2_WAIT: begin
                    if (cp2_ack) begin
                        state_nxt = PSC_RUN;
                    end else if (cnt == CNT_LAST) begin
                        flush_all = 1'b1;
                        redirect  = EXC_VECTOR;
                        exc_take  = 1'b1;
                        exc_cause = CP2_TO_CODE;
                    end else begin
                        stall_all = 1'b1;
                        cnt_nxt   = cnt + 1'b1;
                    end
                end
                PSC_EXC: begin
                    flush_all = 1'b1;
                    redirect  = EXC_VECTOR;
                    state_nxt = PSC_RUN;
                end
                default: state_nxt = PSC_RUN;
            endcase
            if (exc_take) state_nxt = PSC_EXC;
        end
    end

    // NOTE: reset is sampled on the clock edge, and all state uses
    // non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= PSC_RUN;
            cnt      <= '0;
            epc      <= '0;
            exp_code <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (exc_take) begin
                epc      <= mem_pc;
                exp_code <= exc_cause;
            end
        end
    end

    // A load-use bubble holds IF and squashes ID; nothing overlaps stall_all/flush_all.
    assign if_stall   = stall_all | ld_bubble;
    assign id_stall   = stall_all;
    assign ex_stall   = stall_all;
    assign mem_stall  = stall_all;
    assign if_flush   = flush_all;
    assign id_flush   = flush_all | ld_bubble;
    assign ex_flush   = flush_all;
    assign mem_flush  = flush_all;
    assign int_detect = int_hit;
    assign int_type   = int_hit ? INT_CODE : '0;
    assign new_pc     = redirect;
    assign cp2_busy   = reset && (state == PSC_CP2_WAIT);

endmodule
